// File: rtl/outlier_dispatch_scheduler.sv
// Splits one activation vector by magnitude: inliers stream out on the INT lane, the first M
// outliers are buffered and sent on the FP lane afterwards, and any further outliers are saturated.
module outlier_dispatch_scheduler #(
    parameter int unsigned VEC_LEN   = 128,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned INT_W     = 8,
    parameter int unsigned THRESHOLD = 100,
    parameter int unsigned M         = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    output logic                               busy,
    input  logic                               act_valid,
    output logic                               act_ready,
    input  logic signed [DATA_W-1:0]           act_data,
    output logic                               int_valid,
    input  logic                               int_ready,
    output logic signed [INT_W-1:0]            int_data,
    output logic [$clog2(VEC_LEN)-1:0]         int_idx,
    output logic                               int_sat,
    output logic                               fp_valid,
    input  logic                               fp_ready,
    output logic signed [DATA_W-1:0]           fp_data,
    output logic [$clog2(VEC_LEN)-1:0]         fp_idx,
    output logic                               done,
    output logic [$clog2(VEC_LEN+1)-1:0]       outlier_cnt,
    output logic                               overflow
);
    localparam int unsigned IW = $clog2(VEC_LEN);
    localparam int unsigned CW = $clog2(VEC_LEN + 1);
    localparam int unsigned FW = $clog2(M + 1);

    localparam logic signed [DATA_W-1:0] ThrPos = DATA_W'(THRESHOLD);
    localparam logic signed [DATA_W-1:0] ThrNeg = -ThrPos;
    localparam logic signed [INT_W-1:0]  IntMax = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic signed [INT_W-1:0]  IntMin = {1'b1, {(INT_W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

    state_e                    state_q, state_d;
    logic [IW-1:0]             elem_cnt_q, elem_cnt_d;
    logic [CW-1:0]             ocnt_q, ocnt_d;
    logic                      ovf_q, ovf_d;

    logic                      int_valid_q, int_valid_d;
    logic signed [INT_W-1:0]   int_data_q, int_data_d;
    logic [IW-1:0]             int_idx_q, int_idx_d;
    logic                      int_sat_q, int_sat_d;

    logic signed [DATA_W-1:0]  fifo_data_q [M];
    logic signed [DATA_W-1:0]  fifo_data_d [M];
    logic [IW-1:0]             fifo_idx_q [M];
    logic [IW-1:0]             fifo_idx_d [M];
    logic [FW-1:0]             fifo_cnt_q, fifo_cnt_d;

    logic accept;
    logic is_outlier;
    logic fifo_room;
    logic fifo_empty;
    logic fp_pop;

    assign act_ready  = (state_q == StScan) && (!int_valid_q || int_ready);
    assign accept     = act_valid && act_ready;
    assign is_outlier = (act_data > ThrPos) || (act_data < ThrNeg);
    assign fifo_room  = ocnt_q < CW'(M);
    assign fifo_empty = (fifo_cnt_q == '0);
    assign fp_valid   = (state_q == StDrain) && !fifo_empty;
    assign fp_pop     = fp_valid && fp_ready;

    always_comb begin
        state_d     = state_q;
        elem_cnt_d  = elem_cnt_q;
        ocnt_d      = ocnt_q;
        ovf_d       = ovf_q;
        fifo_data_d = fifo_data_q;
        fifo_idx_d  = fifo_idx_q;
        fifo_cnt_d  = fifo_cnt_q;
        // A completed handshake frees the INT register unless a new beat reloads it below.
        int_valid_d = int_valid_q && !int_ready;
        int_data_d  = int_data_q;
        int_idx_d   = int_idx_q;
        int_sat_d   = int_sat_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    elem_cnt_d = '0;
                    ocnt_d     = '0;
                    ovf_d      = 1'b0;
                    fifo_cnt_d = '0;
                    state_d    = StScan;
                end
            end
            StScan: begin
                if (accept) begin
                    elem_cnt_d = elem_cnt_q + 1'b1;
                    if (is_outlier) begin
                        ocnt_d = ocnt_q + 1'b1;
                        if (fifo_room) begin
                            for (int i = 0; i < int'(M); i++) begin
                                if (fifo_cnt_q == FW'(i)) begin
                                    fifo_data_d[i] = act_data;
                                    fifo_idx_d[i]  = elem_cnt_q;
                                end
                            end
                            fifo_cnt_d = fifo_cnt_q + 1'b1;
                        end else begin
                            ovf_d       = 1'b1;
                            int_valid_d = 1'b1;
                            int_data_d  = act_data[DATA_W-1] ? IntMin : IntMax;
                            int_idx_d   = elem_cnt_q;
                            int_sat_d   = 1'b1;
                        end
                    end else begin
                        int_valid_d = 1'b1;
                        int_data_d  = act_data[INT_W-1:0];
                        int_idx_d   = elem_cnt_q;
                        int_sat_d   = 1'b0;
                    end
                    if (elem_cnt_q == IW'(VEC_LEN - 1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Head always sits in entry 0; a pop shifts the rest down.
                if (fp_pop) begin
                    for (int i = 0; i < int'(M) - 1; i++) begin
                        fifo_data_d[i] = fifo_data_q[i+1];
                        fifo_idx_d[i]  = fifo_idx_q[i+1];
                    end
                    fifo_cnt_d = fifo_cnt_q - 1'b1;
                end
                if (fifo_empty && !int_valid_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            elem_cnt_q  <= '0;
            ocnt_q      <= '0;
            ovf_q       <= 1'b0;
            int_valid_q <= 1'b0;
            int_data_q  <= '0;
            int_idx_q   <= '0;
            int_sat_q   <= 1'b0;
            fifo_cnt_q  <= '0;
            for (int i = 0; i < int'(M); i++) begin
                fifo_data_q[i] <= '0;
                fifo_idx_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            elem_cnt_q  <= elem_cnt_d;
            ocnt_q      <= ocnt_d;
            ovf_q       <= ovf_d;
            int_valid_q <= int_valid_d;
            int_data_q  <= int_data_d;
            int_idx_q   <= int_idx_d;
            int_sat_q   <= int_sat_d;
            fifo_cnt_q  <= fifo_cnt_d;
            fifo_data_q <= fifo_data_d;
            fifo_idx_q  <= fifo_idx_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign int_valid   = int_valid_q;
    assign int_data    = int_data_q;
    assign int_idx     = int_idx_q;
    assign int_sat     = int_sat_q;
    assign fp_data     = fifo_data_q[0];
    assign fp_idx      = fifo_idx_q[0];
    assign done        = (state_q == StDone);
    assign outlier_cnt = ocnt_q;
    assign overflow    = ovf_q;

endmodule
